// File: rtl/hazard_ctrl_pkg.sv
// Shared types and forward-select encodings for the hazard controller.
// Optional perf counters in hazard_ctrl are enabled by HAZARD_PERF_EN.
package hazard_ctrl_pkg;

   localparam int REG_AW = 5;
   localparam int SEL_W  = 2;

   typedef logic [REG_AW-1:0] reg_t;
   typedef logic [SEL_W-1:0]  sel_t;

   localparam sel_t FWD_REG = 2'd0;
   localparam sel_t FWD_EX  = 2'd1;
   localparam sel_t FWD_MEM = 2'd2;
   localparam sel_t FWD_WB  = 2'd3;

   typedef struct packed {
      reg_t wa;
      logic we;
      logic ld;
   } stage_t;

   // x0 is hardwired, so it never forwards
   function automatic logic hit(
      input logic we,
      input reg_t wa,
      input reg_t ra
   );
      return we && (wa == ra) && (ra != '0);
   endfunction

endpackage

// File: rtl/hazard_ctrl_fwd_sel.sv
// Per-operand forward-select matcher (fwd_sel): EX > MEM > WB > regfile.
// Used twice by hazard_ctrl, once per source operand.
import hazard_ctrl_pkg::*;

module hazard_ctrl_fwd_sel (
   input  reg_t ra,
   input  logic rd_en,
   input  reg_t ex_wa,
   input  logic ex_we,
   input  reg_t mem_wa,
   input  logic mem_we,
   input  reg_t wb_wa,
   input  logic wb_we,
   output sel_t sel
);

   always_comb begin
      sel = FWD_REG;
      if (!rd_en)
         sel = FWD_REG;
      else if (hit(ex_we, ex_wa, ra))
         sel = FWD_EX;
      else if (hit(mem_we, mem_wa, ra))
         sel = FWD_MEM;
      else if (hit(wb_we, wb_wa, ra))
         sel = FWD_WB;
   end

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: forward selects, load-use/branch stalls, flushes.
// Define HAZARD_PERF_EN to add stall/flush cycle counters.
import hazard_ctrl_pkg::*;

module hazard_ctrl (
   input  logic        clk,
   input  logic        rst,
   input  logic        id_valid_i,
   input  reg_t        id_ra1_i,
   input  reg_t        id_ra2_i,
   input  logic        id_use1_i,
   input  logic        id_use2_i,
   input  reg_t        id_wa_i,
   input  logic        id_we_i,
   input  logic        id_load_i,
   input  logic        id_br_i,
   input  logic        id_taken_i,
   input  logic        mem_wait_i,
   output sel_t        sel_ra1_o,
   output sel_t        sel_ra2_o,
   output logic        stall_if_o,
   output logic        stall_id_o,
   output logic        flush_id_o,
   output logic        bubble_ex_o
`ifdef HAZARD_PERF_EN
   ,
   output logic [31:0] stall_cnt_o,
   output logic [31:0] flush_cnt_o
`endif
);

   stage_t ex_q;
   stage_t mem_q;
   stage_t wb_q;
   stage_t id_s;
   logic   rst_q;
   logic   blk;
   logic   ex_hit;
   logic   hz;
   sel_t   sel1;
   sel_t   sel2;

   hazard_ctrl_fwd_sel u_fwd1 (
      .ra     (id_ra1_i),
      .rd_en  (id_use1_i),
      .ex_wa  (ex_q.wa),
      .ex_we  (ex_q.we),
      .mem_wa (mem_q.wa),
      .mem_we (mem_q.we),
      .wb_wa  (wb_q.wa),
      .wb_we  (wb_q.we),
      .sel    (sel1)
   );

   hazard_ctrl_fwd_sel u_fwd2 (
      .ra     (id_ra2_i),
      .rd_en  (id_use2_i),
      .ex_wa  (ex_q.wa),
      .ex_we  (ex_q.we),
      .mem_wa (mem_q.wa),
      .mem_we (mem_q.we),
      .wb_wa  (wb_q.wa),
      .wb_we  (wb_q.we),
      .sel    (sel2)
   );

   assign ex_hit = (id_use1_i && hit(ex_q.we, ex_q.wa, id_ra1_i))
                || (id_use2_i && hit(ex_q.we, ex_q.wa, id_ra2_i));

   // Loads need MEM; branches compare in ID so even ALU results are too late
   assign hz = id_valid_i && ex_hit && (ex_q.ld || id_br_i);

   // Outputs are quiet during reset and the following cycle
   assign blk = rst || rst_q;

   always_comb begin
      sel_ra1_o   = FWD_REG;
      sel_ra2_o   = FWD_REG;
      stall_if_o  = 1'b0;
      stall_id_o  = 1'b0;
      flush_id_o  = 1'b0;
      bubble_ex_o = 1'b0;
      if (!blk) begin
         sel_ra1_o   = sel1;
         sel_ra2_o   = sel2;
         stall_if_o  = hz || mem_wait_i;
         stall_id_o  = hz || mem_wait_i;
         bubble_ex_o = hz && !mem_wait_i;
         flush_id_o  = id_taken_i && id_valid_i
                    && !hz && !mem_wait_i;
      end
   end

   assign id_s = '{
      wa: id_wa_i,
      we: id_we_i && id_valid_i,
      ld: id_load_i && id_valid_i
   };

   always_ff @(posedge clk) begin
      if (rst) begin
         ex_q  <= '0;
         mem_q <= '0;
         wb_q  <= '0;
         rst_q <= 1'b1;
      end else begin
         rst_q <= 1'b0;
         if (!mem_wait_i) begin
            wb_q  <= mem_q;
            mem_q <= ex_q;
            ex_q  <= bubble_ex_o ? '0 : id_s;
         end
      end
   end

`ifdef HAZARD_PERF_EN
   always_ff @(posedge clk) begin
      if (rst) begin
         stall_cnt_o <= '0;
         flush_cnt_o <= '0;
      end else begin
         if (bubble_ex_o && (stall_cnt_o != '1))
            stall_cnt_o <= stall_cnt_o + 32'd1;
         if (flush_id_o && (flush_cnt_o != '1))
            flush_cnt_o <= flush_cnt_o + 32'd1;
      end
   end
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// Bench for hazard_ctrl: directed table of pipeline scenarios, then
// random traffic checked against a queue-based pipeline model.
module tb_hazard_ctrl;

   typedef struct {
      logic       rst, v;
      logic [4:0] ra1, ra2;
      logic       u1, u2;
      logic [4:0] wa;
      logic       we, ld, br, tk, mw;
      logic [1:0] s1, s2;
      logic       st, fl, bx;
   } vec_t;

   typedef struct {
      logic [4:0] wa;
      logic       we, ld;
   } ent_t;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       id_valid_i = 1'b0;
   logic [4:0] id_ra1_i = '0;
   logic [4:0] id_ra2_i = '0;
   logic       id_use1_i = 1'b0;
   logic       id_use2_i = 1'b0;
   logic [4:0] id_wa_i = '0;
   logic       id_we_i = 1'b0;
   logic       id_load_i = 1'b0;
   logic       id_br_i = 1'b0;
   logic       id_taken_i = 1'b0;
   logic       mem_wait_i = 1'b0;
   logic [1:0] sel_ra1_o, sel_ra2_o;
   logic       stall_if_o, stall_id_o, flush_id_o, bubble_ex_o;
`ifdef HAZARD_PERF_EN
   logic [31:0] stall_cnt_o, flush_cnt_o;
`endif

   int nvec = 0;
   int nmis = 0;

   ent_t pipe[$];
   logic rst_prev = 1'b0;
   vec_t tbl[$];

   always #5 clk = ~clk;

   hazard_ctrl dut (
      .clk         (clk),
      .rst         (rst),
      .id_valid_i  (id_valid_i),
      .id_ra1_i    (id_ra1_i),
      .id_ra2_i    (id_ra2_i),
      .id_use1_i   (id_use1_i),
      .id_use2_i   (id_use2_i),
      .id_wa_i     (id_wa_i),
      .id_we_i     (id_we_i),
      .id_load_i   (id_load_i),
      .id_br_i     (id_br_i),
      .id_taken_i  (id_taken_i),
      .mem_wait_i  (mem_wait_i),
      .sel_ra1_o   (sel_ra1_o),
      .sel_ra2_o   (sel_ra2_o),
      .stall_if_o  (stall_if_o),
      .stall_id_o  (stall_id_o),
      .flush_id_o  (flush_id_o),
      .bubble_ex_o (bubble_ex_o)
`ifdef HAZARD_PERF_EN
      ,
      .stall_cnt_o (stall_cnt_o),
      .flush_cnt_o (flush_cnt_o)
`endif
   );

   function automatic vec_t mk(
      input int rst_, v, ra1, u1, ra2, u2, wa, we, ld, br, tk, mw,
      input int s1, s2, st, fl, bx
   );
      vec_t r;
      r.rst = 1'(rst_); r.v = 1'(v);
      r.ra1 = 5'(ra1); r.u1 = 1'(u1);
      r.ra2 = 5'(ra2); r.u2 = 1'(u2);
      r.wa = 5'(wa); r.we = 1'(we); r.ld = 1'(ld);
      r.br = 1'(br); r.tk = 1'(tk); r.mw = 1'(mw);
      r.s1 = 2'(s1); r.s2 = 2'(s2);
      r.st = 1'(st); r.fl = 1'(fl); r.bx = 1'(bx);
      return r;
   endfunction

   // Youngest in-flight writer of ra: queue index 0=EX, 1=MEM, 2=WB
   function automatic logic [1:0] msel(input logic [4:0] ra, input logic u);
      if (!u || ra == 5'd0) return 2'd0;
      for (int k = 0; k < 3; k++)
         if (pipe[k].we && pipe[k].wa == ra) return 2'(k + 1);
      return 2'd0;
   endfunction

   function automatic vec_t model_expect(input vec_t v);
      vec_t r = v;
      logic blk, dep, hz;
      blk = v.rst || rst_prev;
      dep = (msel(v.ra1, v.u1) == 2'd1) || (msel(v.ra2, v.u2) == 2'd1);
      hz = v.v && dep && (pipe[0].ld || v.br);
      r.s1 = blk ? 2'd0 : msel(v.ra1, v.u1);
      r.s2 = blk ? 2'd0 : msel(v.ra2, v.u2);
      r.st = !blk && (hz || v.mw);
      r.bx = !blk && hz && !v.mw;
      r.fl = !blk && v.tk && v.v && !hz && !v.mw;
      return r;
   endfunction

   task automatic model_step(input vec_t v);
      vec_t m;
      ent_t e;
      m = model_expect(v);
      if (v.rst) begin
         pipe = '{'{5'd0, 1'b0, 1'b0}, '{5'd0, 1'b0, 1'b0}, '{5'd0, 1'b0, 1'b0}};
         rst_prev = 1'b1;
      end else begin
         rst_prev = 1'b0;
         if (!v.mw) begin
            e = m.bx ? '{5'd0, 1'b0, 1'b0}
                     : '{v.wa, v.we && v.v, v.ld && v.v};
            void'(pipe.pop_back());
            pipe.push_front(e);
         end
      end
   endtask

   task automatic run(input vec_t v, input string name);
      @(negedge clk);
      rst = v.rst; id_valid_i = v.v;
      id_ra1_i = v.ra1; id_use1_i = v.u1;
      id_ra2_i = v.ra2; id_use2_i = v.u2;
      id_wa_i = v.wa; id_we_i = v.we; id_load_i = v.ld;
      id_br_i = v.br; id_taken_i = v.tk; mem_wait_i = v.mw;
      #2;
      nvec++;
      if ({sel_ra1_o, sel_ra2_o, stall_if_o, stall_id_o, flush_id_o, bubble_ex_o}
          !== {v.s1, v.s2, v.st, v.st, v.fl, v.bx}) begin
         nmis++;
         $display("FAIL %s: got s1=%0d s2=%0d sif=%b sid=%b fl=%b bx=%b want s1=%0d s2=%0d sif=%b sid=%b fl=%b bx=%b",
                  name, sel_ra1_o, sel_ra2_o, stall_if_o, stall_id_o, flush_id_o, bubble_ex_o,
                  v.s1, v.s2, v.st, v.st, v.fl, v.bx);
      end
      model_step(v);
   endtask

   initial begin
      vec_t v;
      pipe = '{'{5'd0, 1'b0, 1'b0}, '{5'd0, 1'b0, 1'b0}, '{5'd0, 1'b0, 1'b0}};

      // rst v ra1 u1 ra2 u2 wa we ld br tk mw | s1 s2 st fl bx
      tbl.push_back(mk(1,1, 5,1, 0,0, 5,1,0, 0,0,0, 0,0,0,0,0));
      tbl.push_back(mk(0,1, 5,1, 0,0, 5,1,0, 1,1,0, 0,0,0,0,0));
      tbl.push_back(mk(0,1, 5,1, 0,0, 6,1,1, 0,0,0, 1,0,0,0,0));
      tbl.push_back(mk(0,1, 5,1, 6,1, 7,1,0, 0,0,0, 2,1,1,0,1));
      tbl.push_back(mk(0,1, 5,1, 6,1, 7,1,0, 0,0,0, 3,2,0,0,0));
      tbl.push_back(mk(0,1, 0,1, 7,1, 0,1,0, 0,0,0, 0,1,0,0,0));
      tbl.push_back(mk(0,1, 0,1, 7,0, 7,1,0, 0,0,0, 0,0,0,0,0));
      tbl.push_back(mk(0,1, 7,1, 7,1, 3,0,0, 0,0,0, 1,1,0,0,0));
      tbl.push_back(mk(0,1, 1,1, 2,1, 0,0,0, 1,1,0, 0,0,0,1,0));
      tbl.push_back(mk(0,0, 7,1, 0,0, 0,0,0, 0,0,0, 3,0,0,0,0));
      tbl.push_back(mk(0,1, 0,0, 0,0, 9,1,1, 0,0,0, 0,0,0,0,0));
      tbl.push_back(mk(0,1, 9,1, 0,0, 0,0,0, 1,1,0, 1,0,1,0,1));
      tbl.push_back(mk(0,1, 9,1, 0,0, 0,0,0, 1,1,0, 2,0,0,1,0));
      tbl.push_back(mk(0,1, 0,0, 0,0,10,1,0, 0,0,0, 0,0,0,0,0));
      tbl.push_back(mk(0,1,10,1, 0,0, 0,0,0, 1,0,0, 1,0,1,0,1));
      tbl.push_back(mk(0,1,10,1, 0,0, 0,0,0, 1,0,0, 2,0,0,0,0));
      tbl.push_back(mk(0,1, 0,0, 0,0,11,1,1, 0,0,0, 0,0,0,0,0));
      tbl.push_back(mk(0,1,11,1, 0,0,12,1,0, 0,0,1, 1,0,1,0,0));
      tbl.push_back(mk(0,1,11,1, 0,0,12,1,0, 0,0,1, 1,0,1,0,0));
      tbl.push_back(mk(0,1,11,1, 0,0,12,1,0, 0,0,1, 1,0,1,0,0));
      tbl.push_back(mk(1,1,11,1, 0,0,12,1,0, 0,0,1, 0,0,0,0,0));
      tbl.push_back(mk(0,1,11,1, 0,0,12,1,0, 0,0,0, 0,0,0,0,0));
      tbl.push_back(mk(0,1,12,1, 0,0, 0,0,0, 0,0,0, 1,0,0,0,0));
      tbl.push_back(mk(0,1, 0,0, 0,0, 0,0,0, 1,1,1, 0,0,1,0,0));
      tbl.push_back(mk(0,1, 0,0, 0,0, 0,0,0, 1,1,0, 0,0,0,1,0));

      foreach (tbl[i])
         run(tbl[i], $sformatf("dir%0d", i));

      for (int n = 0; n < 600; n++) begin
         v.rst = ($urandom_range(0, 39) == 0);
         v.v   = ($urandom_range(0, 4) != 0);
         v.ra1 = 5'($urandom_range(0, 7));
         v.ra2 = 5'($urandom_range(0, 7));
         v.u1  = 1'($urandom_range(0, 1));
         v.u2  = 1'($urandom_range(0, 1));
         v.wa  = 5'($urandom_range(0, 7));
         v.we  = ($urandom_range(0, 3) != 0);
         v.ld  = ($urandom_range(0, 2) == 0);
         v.br  = ($urandom_range(0, 3) == 0);
         v.tk  = v.br && ($urandom_range(0, 1) == 1);
         v.mw  = ($urandom_range(0, 5) == 0);
         v = model_expect(v);
         run(v, $sformatf("rand%0d", n));
      end

      $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
      $finish;
   end

endmodule
